// File: rtl/timer_counter_unit.sv
// Timer/counter with prescaler, two output-compare channels and
// normal / CTC / fast-PWM waveform generation, plus sticky W1C status flags.
module timer_counter_unit #(
    parameter int WIDTH = 16
) (
    input  logic             sysClock,
    input  logic             sysReset_n,
    input  logic [2:0]       cs,
    input  logic [1:0]       wgm,
    input  logic             tcnt_wr_en,
    input  logic [WIDTH-1:0] tcnt_wr_data,
    input  logic             ocra_wr_en,
    input  logic [WIDTH-1:0] ocra_wr_data,
    input  logic             ocrb_wr_en,
    input  logic [WIDTH-1:0] ocrb_wr_data,
    input  logic [2:0]       flag_clr,
    output logic [WIDTH-1:0] tcnt,
    output logic [WIDTH-1:0] ocra,
    output logic [WIDTH-1:0] ocrb,
    output logic [2:0]       flags,
    output logic             oca,
    output logic             ocb
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_CTC    = 2'd1,
        MODE_PWM    = 2'd2
    } mode_t;

    mode_t            mode;
    logic [9:0]       prescaler_reg;
    logic             tick;
    logic             count_en;
    logic             wrap;
    logic [WIDTH-1:0] tcnt_reg;
    logic [WIDTH-1:0] tcnt_next;
    logic [2:0]       flags_reg;
    logic [2:0]       flags_next;

    // Per-channel views: index 0 is channel A, index 1 is channel B.
    logic [1:0]            ocr_wr_en;
    logic [1:0][WIDTH-1:0] ocr_wr_data;
    logic [1:0][WIDTH-1:0] ocr_buf;
    logic [1:0][WIDTH-1:0] ocr_act;
    logic [1:0]            match;
    logic [1:0]            oc;

    assign ocr_wr_en      = {ocrb_wr_en, ocra_wr_en};
    assign ocr_wr_data[0] = ocra_wr_data;
    assign ocr_wr_data[1] = ocrb_wr_data;

    always_comb begin
        mode = MODE_NORMAL;
        case (wgm)
            2'd1:    mode = MODE_CTC;
            2'd2:    mode = MODE_PWM;
            default: mode = MODE_NORMAL;
        endcase
    end

    always_ff @(posedge sysClock) begin
        if (!sysReset_n) begin
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + 10'd1;
        end
    end

    // A divide-by-N tick fires when the low log2(N) prescaler bits are all ones.
    always_comb begin
        tick = 1'b0;
        case (cs)
            3'd1:    tick = 1'b1;
            3'd2:    tick = &prescaler_reg[2:0];
            3'd3:    tick = &prescaler_reg[5:0];
            3'd4:    tick = &prescaler_reg[7:0];
            3'd5:    tick = &prescaler_reg[9:0];
            default: tick = 1'b0;
        endcase
    end

    assign count_en = tick & ~tcnt_wr_en;
    // MAX->0 happens in every mode when counting from MAX, including a CTC
    // clear with OCRA == MAX, so one overflow term serves all modes.
    assign wrap = count_en && (tcnt_reg == MAX);

    always_comb begin
        tcnt_next = tcnt_reg;
        if (tcnt_wr_en) begin
            tcnt_next = tcnt_wr_data;
        end else if (tick) begin
            if ((mode == MODE_CTC) && (tcnt_reg == ocr_act[0])) begin
                tcnt_next = '0;
            end else begin
                tcnt_next = tcnt_reg + ONE;
            end
        end
    end

    always_ff @(posedge sysClock) begin
        if (!sysReset_n) begin
            tcnt_reg <= '0;
        end else begin
            tcnt_reg <= tcnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_channel
            logic [WIDTH-1:0] buf_reg;
            logic [WIDTH-1:0] buf_next;
            logic [WIDTH-1:0] act_reg;
            logic [WIDTH-1:0] act_next;
            logic             oc_reg;
            logic             oc_next;
            logic             ch_match;

            assign ch_match = count_en && (tcnt_reg == act_reg);

            always_comb begin
                buf_next = buf_reg;
                if (ocr_wr_en[gi]) begin
                    buf_next = ocr_wr_data[gi];
                end
            end

            // PWM double-buffers until the wrap; other modes track the buffer,
            // which also reloads the active value on leaving PWM.
            always_comb begin
                act_next = buf_next;
                if (mode == MODE_PWM) begin
                    act_next = wrap ? buf_next : act_reg;
                end
            end

            always_comb begin
                oc_next = oc_reg ^ ch_match;
                if (mode == MODE_PWM) begin
                    oc_next = (tcnt_next <= act_next);
                end
            end

            always_ff @(posedge sysClock) begin
                if (!sysReset_n) begin
                    buf_reg <= '0;
                    act_reg <= '0;
                    oc_reg  <= 1'b0;
                end else begin
                    buf_reg <= buf_next;
                    act_reg <= act_next;
                    oc_reg  <= oc_next;
                end
            end

            assign ocr_buf[gi] = buf_reg;
            assign ocr_act[gi] = act_reg;
            assign match[gi]   = ch_match;
            assign oc[gi]      = oc_reg;
        end
    endgenerate

    // Setting has priority over a simultaneous write-1-to-clear.
    assign flags_next = (flags_reg & ~flag_clr) | {match[1], match[0], wrap};

    always_ff @(posedge sysClock) begin
        if (!sysReset_n) begin
            flags_reg <= '0;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign tcnt  = tcnt_reg;
    assign ocra  = ocr_buf[0];
    assign ocrb  = ocr_buf[1];
    assign flags = flags_reg;
    assign oca   = oc[0];
    assign ocb   = oc[1];

endmodule

// File: tb/tb_timer_counter_unit.sv
// Directed bench for timer_counter_unit: a vector table for normal/CTC counting
// plus hand-written sequences for prescaling, fast PWM, preload blocking and reset.
module tb_timer_counter_unit;

    logic        sysClock = 1'b0;
    logic        sysReset_n;
    logic [2:0]  cs;
    logic [1:0]  wgm;
    logic        tcnt_wr_en;
    logic [15:0] tcnt_wr_data;
    logic        ocra_wr_en;
    logic [15:0] ocra_wr_data;
    logic        ocrb_wr_en;
    logic [15:0] ocrb_wr_data;
    logic [2:0]  flag_clr;
    logic [15:0] tcnt;
    logic [15:0] ocra;
    logic [15:0] ocrb;
    logic [2:0]  flags;
    logic        oca;
    logic        ocb;

    int checks = 0;
    int failures = 0;

    timer_counter_unit #(.WIDTH(16)) dut (
        .sysClock     (sysClock),
        .sysReset_n   (sysReset_n),
        .cs           (cs),
        .wgm          (wgm),
        .tcnt_wr_en   (tcnt_wr_en),
        .tcnt_wr_data (tcnt_wr_data),
        .ocra_wr_en   (ocra_wr_en),
        .ocra_wr_data (ocra_wr_data),
        .ocrb_wr_en   (ocrb_wr_en),
        .ocrb_wr_data (ocrb_wr_data),
        .flag_clr     (flag_clr),
        .tcnt         (tcnt),
        .ocra         (ocra),
        .ocrb         (ocrb),
        .flags        (flags),
        .oca          (oca),
        .ocb          (ocb)
    );

    always #5 sysClock = ~sysClock;

    typedef struct {
        logic [2:0]  cs;
        logic [1:0]  wgm;
        logic        twe;
        logic [15:0] twd;
        logic [2:0]  clr;
        logic [15:0] e_tcnt;
        logic [2:0]  e_flags;
        logic        e_oca;
        logic        e_ocb;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(logic [2:0] c, logic [1:0] w, logic we, logic [15:0] wd,
                                logic [2:0] cl, logic [15:0] et, logic [2:0] ef, logic ea);
        vec_t v;
        v.cs = c; v.wgm = w; v.twe = we; v.twd = wd; v.clr = cl;
        v.e_tcnt = et; v.e_flags = ef; v.e_oca = ea; v.e_ocb = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysClock);
        #1;
    endtask

    task automatic idle_strobes();
        tcnt_wr_en = 1'b0; ocra_wr_en = 1'b0; ocrb_wr_en = 1'b0; flag_clr = 3'b000;
    endtask

    initial begin
        int changes;
        int last_k;
        logic [15:0] prev;

        // Normal wrap and W1C behaviour, then CTC with OCRA=4, then CTC preload above OCRA.
        tbl[0]  = mk(1, 0, 1, 16'hFFFE, 0, 16'hFFFE, 3'b000, 0);
        tbl[1]  = mk(1, 0, 0, 16'h0000, 0, 16'hFFFF, 3'b000, 0);
        tbl[2]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 3'b001, 0);
        tbl[3]  = mk(1, 0, 0, 16'h0000, 1, 16'h0001, 3'b000, 0);
        tbl[4]  = mk(1, 0, 1, 16'hFFFF, 0, 16'hFFFF, 3'b000, 0);
        tbl[5]  = mk(1, 0, 0, 16'h0000, 1, 16'h0000, 3'b001, 0);
        tbl[6]  = mk(1, 0, 0, 16'h0000, 1, 16'h0001, 3'b000, 0);
        tbl[7]  = mk(1, 1, 1, 16'h0000, 0, 16'h0000, 3'b000, 0);
        tbl[8]  = mk(1, 1, 0, 16'h0000, 0, 16'h0001, 3'b000, 0);
        tbl[9]  = mk(1, 1, 0, 16'h0000, 0, 16'h0002, 3'b000, 0);
        tbl[10] = mk(1, 1, 0, 16'h0000, 0, 16'h0003, 3'b000, 0);
        tbl[11] = mk(1, 1, 0, 16'h0000, 0, 16'h0004, 3'b000, 0);
        tbl[12] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 3'b010, 1);
        tbl[13] = mk(1, 1, 0, 16'h0000, 2, 16'h0001, 3'b000, 1);
        tbl[14] = mk(1, 1, 0, 16'h0000, 0, 16'h0002, 3'b000, 1);
        tbl[15] = mk(1, 1, 0, 16'h0000, 0, 16'h0003, 3'b000, 1);
        tbl[16] = mk(1, 1, 0, 16'h0000, 0, 16'h0004, 3'b000, 1);
        tbl[17] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 3'b010, 0);
        tbl[18] = mk(1, 1, 1, 16'h0006, 0, 16'h0006, 3'b010, 0);
        tbl[19] = mk(1, 1, 0, 16'h0000, 0, 16'h0007, 3'b010, 0);
        tbl[20] = mk(1, 1, 1, 16'hFFFE, 2, 16'hFFFE, 3'b000, 0);
        tbl[21] = mk(1, 1, 0, 16'h0000, 0, 16'hFFFF, 3'b000, 0);
        tbl[22] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 3'b001, 0);
        tbl[23] = mk(1, 1, 0, 16'h0000, 0, 16'h0001, 3'b001, 0);
        tbl[24] = mk(1, 1, 0, 16'h0000, 0, 16'h0002, 3'b001, 0);
        tbl[25] = mk(1, 1, 0, 16'h0000, 0, 16'h0003, 3'b001, 0);
        tbl[26] = mk(1, 1, 0, 16'h0000, 0, 16'h0004, 3'b001, 0);
        tbl[27] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 3'b011, 1);

        sysReset_n = 1'b0; cs = 3'd0; wgm = 2'd0;
        tcnt_wr_data = '0; ocra_wr_data = '0; ocrb_wr_data = '0;
        idle_strobes();
        step(); step();
        chk("rst_tcnt", tcnt, 16'h0000);
        chk("rst_flags", flags, 3'b000);
        chk("rst_oca", oca, 1'b0);
        chk("rst_ocb", ocb, 1'b0);

        sysReset_n = 1'b1;
        ocra_wr_en = 1'b1; ocra_wr_data = 16'h0004;
        ocrb_wr_en = 1'b1; ocrb_wr_data = 16'h8000;
        step();
        chk("ocra_wr", ocra, 16'h0004);
        chk("ocrb_wr", ocrb, 16'h8000);
        chk("stopped_tcnt", tcnt, 16'h0000);
        idle_strobes();

        for (int i = 0; i < 28; i++) begin
            cs = tbl[i].cs; wgm = tbl[i].wgm;
            tcnt_wr_en = tbl[i].twe; tcnt_wr_data = tbl[i].twd; flag_clr = tbl[i].clr;
            step();
            $display("row %0d: tcnt=%04h flags=%03b oca=%0b ocb=%0b", i, tcnt, flags, oca, ocb);
            chk($sformatf("row%0d_tcnt", i), tcnt, tbl[i].e_tcnt);
            chk($sformatf("row%0d_flags", i), flags, tbl[i].e_flags);
            chk($sformatf("row%0d_oca", i), oca, tbl[i].e_oca);
            chk($sformatf("row%0d_ocb", i), ocb, tbl[i].e_ocb);
        end
        idle_strobes();

        // Prescaler /8: any 64 consecutive edges hold exactly 8 evenly spaced ticks.
        wgm = 2'd0; cs = 3'd2; tcnt_wr_en = 1'b1; tcnt_wr_data = 16'h0000; flag_clr = 3'b111;
        step();
        idle_strobes();
        chk("presc_preload", tcnt, 16'h0000);
        changes = 0; last_k = 0;
        for (int k = 0; k < 64; k++) begin
            prev = tcnt;
            step();
            if (tcnt != prev) begin
                changes++;
                if (changes > 1) chk("presc_gap", k - last_k, 8);
                last_k = k;
            end
        end
        $display("presc /8: %0d increments in 64 cycles, tcnt=%04h", changes, tcnt);
        chk("presc_count", changes, 8);
        chk("presc_tcnt", tcnt, 16'h0008);
        cs = 3'd0;
        for (int k = 0; k < 100; k++) step();
        chk("cs0_frozen", tcnt, 16'h0008);
        cs = 3'd7;
        for (int k = 0; k < 20; k++) step();
        chk("cs7_frozen", tcnt, 16'h0008);

        // Fast PWM with double-buffered OCRA.
        cs = 3'd0; ocra_wr_en = 1'b1; ocra_wr_data = 16'h3FFF;
        step();
        idle_strobes();
        wgm = 2'd2; cs = 3'd1; tcnt_wr_en = 1'b1; tcnt_wr_data = 16'h3FFE;
        step();
        idle_strobes();
        $display("pwm: tcnt=%04h oca=%0b", tcnt, oca);
        chk("pwm_3ffe_oca", oca, 1'b1);
        step();
        chk("pwm_3fff_tcnt", tcnt, 16'h3FFF);
        chk("pwm_3fff_oca", oca, 1'b1);
        step();
        chk("pwm_4000_oca", oca, 1'b0);
        ocra_wr_en = 1'b1; ocra_wr_data = 16'h7FFF;
        step();
        idle_strobes();
        chk("pwm_ocra_read", ocra, 16'h7FFF);
        chk("pwm_4001_tcnt", tcnt, 16'h4001);
        tcnt_wr_en = 1'b1; tcnt_wr_data = 16'h5000;
        step();
        chk("pwm_old_duty", oca, 1'b0);
        tcnt_wr_data = 16'hFFFF; flag_clr = 3'b111;
        step();
        idle_strobes();
        chk("pwm_max_oca", oca, 1'b0);
        step();
        $display("pwm wrap: tcnt=%04h flags=%03b oca=%0b", tcnt, flags, oca);
        chk("pwm_wrap_tcnt", tcnt, 16'h0000);
        chk("pwm_wrap_tov", flags[0], 1'b1);
        chk("pwm_wrap_oca", oca, 1'b1);
        tcnt_wr_en = 1'b1; tcnt_wr_data = 16'h5000;
        step();
        chk("pwm_new_duty", oca, 1'b1);
        chk("pwm_ocb", ocb, 1'b1);

        // Preload blocks compare match on channel B.
        wgm = 2'd0; tcnt_wr_data = 16'h8000; flag_clr = 3'b111;
        step();
        flag_clr = 3'b000;
        chk("blk_pre_tcnt", tcnt, 16'h8000);
        chk("blk_pre_flags", flags, 3'b000);
        tcnt_wr_data = 16'h1111;
        step();
        $display("blocked: tcnt=%04h flags=%03b ocb=%0b", tcnt, flags, ocb);
        chk("blk_tcnt", tcnt, 16'h1111);
        chk("blk_flags", flags, 3'b000);
        chk("blk_ocb", ocb, 1'b1);
        tcnt_wr_data = 16'h8000;
        step();
        tcnt_wr_en = 1'b0;
        step();
        chk("match_tcnt", tcnt, 16'h8001);
        chk("match_flags", flags, 3'b100);
        chk("match_ocb", ocb, 1'b0);

        // Reset mid-count wins over a simultaneous preload and compare write.
        tcnt_wr_en = 1'b1; tcnt_wr_data = 16'h1230;
        step();
        tcnt_wr_en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_tcnt", tcnt, 16'h1234);
        chk("pre_rst_flags", flags, 3'b100);
        sysReset_n = 1'b0; tcnt_wr_en = 1'b1; tcnt_wr_data = 16'hAAAA;
        ocra_wr_en = 1'b1; ocra_wr_data = 16'h5555;
        step();
        $display("reset: tcnt=%04h flags=%03b ocra=%04h", tcnt, flags, ocra);
        chk("rst2_tcnt", tcnt, 16'h0000);
        chk("rst2_flags", flags, 3'b000);
        chk("rst2_oca", oca, 1'b0);
        chk("rst2_ocb", ocb, 1'b0);
        chk("rst2_ocra", ocra, 16'h0000);
        chk("rst2_ocrb", ocrb, 16'h0000);
        sysReset_n = 1'b1; cs = 3'd0;
        idle_strobes();
        step();
        chk("post_rst_tcnt", tcnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_counter_unit.md
Name: timer_counter_unit

Overview:
- Parametrised next-generation timer/counter: WIDTH-bit counter, on-chip clock prescaler, two output-compare channels (A/B), three waveform modes (normal, CTC, fast PWM).
- Sticky TOV/OCFA/OCFB flags with write-1-to-clear.
- Sits beside the register file; the CPU-side glue drives write strobes and reads back the counter and flags.

Parameters:
- WIDTH, 16, counter/compare width in bits (>=2); MAX = 2^WIDTH-1.

Ports:
- sysClock  in  1  system clock, all logic on rising edge
- sysReset_n  in  1  synchronous active-low reset
- cs  in  3  clock select: 0 stop, 1 /1, 2 /8, 3 /64, 4 /256, 5 /1024, 6-7 stop
- wgm  in  2  mode: 0 normal, 1 CTC (TOP=OCRA), 2 fast PWM (TOP=MAX), 3 treated as normal
- tcnt_wr_en  in  1  preload counter
- tcnt_wr_data  in  WIDTH  preload value
- ocra_wr_en / ocrb_wr_en  in  1  compare register write strobes
- ocra_wr_data / ocrb_wr_data  in  WIDTH  compare write values
- flag_clr  in  3  write-1-to-clear: bit0 TOV, bit1 OCFA, bit2 OCFB
- tcnt  out  WIDTH  counter value
- ocra / ocrb  out  WIDTH  buffered (last written) compare values
- flags  out  3  {OCFB, OCFA, TOV}
- oca / ocb  out  1  waveform outputs

Behaviour:
- Reset (sysReset_n=0 at an edge): prescaler, tcnt, ocr buffers, active ocr, flags, oca, ocb all 0. Takes priority over every other input, including mid-count.
- Prescaler: 10-bit free-running counter, increments every sysClock, cleared only by reset.
  - tick=1 every cycle for cs=1.
  - For /N, tick=1 when low log2(N) prescaler bits are all ones, i.e. one tick per N cycles.
  - No ticks for cs=0/6/7; the counter holds.
- Counter priority per edge:
  - tcnt_wr_en: tcnt<=tcnt_wr_data. No increment, no compare match, no TOV that cycle, even if tick=1.
  - Otherwise, on tick: advance per mode.
  - Otherwise: hold.
- Normal mode: tcnt<=tcnt+1 mod 2^WIDTH. TOV set on the edge where tcnt goes MAX->0.
- CTC mode:
  - If tcnt==OCRA_act at tick: tcnt<=0.
  - Else: tcnt+1, with MAX->0 wrap setting TOV. This covers a preload above OCRA; with OCRA_act==MAX, TOV and OCFA are set together.
- Fast PWM mode: count 0..MAX and wrap. TOV set on the wrap edge.
- Compare match X (A or B): tick && !tcnt_wr_en && tcnt==OCRX_act, evaluated on the pre-update value. Sets OCFX on that same edge.
- Flags:
  - Sticky.
  - flag_clr bit clears its flag at the edge.
  - Simultaneous set and clear: set wins.
- OCR writes:
  - Normal/CTC: write updates buffer and active register at the same edge.
  - Fast PWM: write updates buffer only. Active <= buffer on the wrap tick (MAX->0).
  - On entering normal/CTC from PWM: active <= buffer at the first edge.
  - A write coinciding with the wrap tick: the new data reaches active at that edge.
- Waveform outputs (registered):
  - Normal/CTC: ocX toggles at each compare-match edge.
  - Fast PWM: ocX <= (tcnt_next <= OCRX_act_next), so ocX changes at the same edge as tcnt.
  - Consequences: OCRX=MAX gives constant 1; OCRX=0 gives 1 for one count per period.
- Mode change mid-count: tcnt is not cleared; the new mode rules apply from the next edge.
- Counter arithmetic is WIDTH bits, no carry kept.

Test Plan:
- Reset: run cs=1 to tcnt=0x1234, set flags, then sysReset_n=0 one edge -> tcnt=0, flags=0, oca=ocb=0, ocra=0.
- Normal, cs=1: preload 0xFFFE -> tcnt 0xFFFF, then 0x0000 with flags[0]=1 on that edge. flag_clr=001 -> TOV 0. flag_clr=001 on a wrap edge -> TOV stays 1.
- CTC, cs=1, OCRA=4: tcnt sequence 0,1,2,3,4,0. OCFA set on the 4->0 edge. oca toggles every 5 cycles (period 10). Preload 6 -> counts to 0xFFFF, wraps with TOV, then matches at 4.
- Prescaler cs=2, normal: tcnt increments exactly once per 8 sysClock. cs=0 -> tcnt frozen for 100 cycles.
- Fast PWM, cs=1, OCRA=0x3FFF: oca=1 while tcnt<=0x3FFF, else 0. Write OCRA=0x7FFF mid-period -> ocra reads 0x7FFF immediately, but duty changes only after the next MAX->0 wrap.
- Blocking: tcnt_wr_en with tcnt==OCRB_act and tick=1 -> OCFB not set, ocb unchanged, tcnt=preload.
